// File: rtl/video_timing_pkg.sv
// rtl/video_timing_pkg.sv - default 15 kHz video timing constants and pattern encodings
package video_timing_pkg;

  localparam int unsigned H_TOTAL  = 1024;
  localparam int unsigned H_SYNC   = 72;
  localparam int unsigned H_START  = 192;
  localparam int unsigned H_ACTIVE = 640;
  localparam int unsigned V_TOTAL  = 312;
  localparam int unsigned V_SYNC   = 3;
  localparam int unsigned V_START  = 40;
  localparam int unsigned V_ACTIVE = 256;

  typedef enum logic [1:0] {
    PAT_EXT   = 2'b00,
    PAT_BARS  = 2'b01,
    PAT_GRID  = 2'b10,
    PAT_BLACK = 2'b11
  } pattern_t;

endpackage

// File: rtl/video_pattern.sv
// rtl/video_pattern.sv - combinational colour selection: external pixel or built-in test pattern
module video_pattern
  import video_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE = video_timing_pkg::H_ACTIVE,
  parameter int unsigned V_ACTIVE = video_timing_pkg::V_ACTIVE
) (
  input  logic [9:0]  x,
  input  logic [8:0]  y,
  input  pattern_t    pat,
  input  logic [17:0] pix_rgb,
  output logic [17:0] rgb
);

  // Eight equal-width bars across the active line.
  localparam logic [9:0] BAR_W  = 10'(H_ACTIVE / 8);
  localparam logic [9:0] X_LAST = 10'(H_ACTIVE - 1);
  localparam logic [8:0] Y_LAST = 9'(V_ACTIVE - 1);

  logic [9:0] bar_idx;
  logic       grid_on;

  assign bar_idx = x / BAR_W;
  // Grid lines every 32 pixels/lines plus a closing border on the last column and row.
  assign grid_on = (x[4:0] == 5'd0) || (y[4:0] == 5'd0) || (x == X_LAST) || (y == Y_LAST);

  // Select the colour source; bar index bits map to r=bit1, g=bit2, b=bit0.
  always_comb begin
    rgb = '0;
    case (pat)
      PAT_EXT:   rgb = pix_rgb;
      PAT_BARS:  rgb = {{6{bar_idx[1]}}, {6{bar_idx[2]}}, {6{bar_idx[0]}}};
      PAT_GRID:  rgb = {18{grid_on}};
      default:   rgb = '0;
    endcase
  end

endmodule

// File: rtl/video_sync_gen.sv
// rtl/video_sync_gen.sv - 15 kHz sync/pixel-request timing generator with one-cycle output stage
module video_sync_gen
  import video_timing_pkg::*;
#(
  parameter int unsigned H_TOTAL  = video_timing_pkg::H_TOTAL,
  parameter int unsigned H_SYNC   = video_timing_pkg::H_SYNC,
  parameter int unsigned H_START  = video_timing_pkg::H_START,
  parameter int unsigned H_ACTIVE = video_timing_pkg::H_ACTIVE,
  parameter int unsigned V_TOTAL  = video_timing_pkg::V_TOTAL,
  parameter int unsigned V_SYNC   = video_timing_pkg::V_SYNC,
  parameter int unsigned V_START  = video_timing_pkg::V_START,
  parameter int unsigned V_ACTIVE = video_timing_pkg::V_ACTIVE
) (
  input  logic        clk_pix,
  input  logic        rst_n,
  input  logic        clken_pix,
  input  logic [1:0]  pattern,
  output logic        pix_req,
  output logic [9:0]  pix_x,
  output logic [8:0]  pix_y,
  input  logic [17:0] pix_rgb,
  output logic        hs_out,
  output logic        vs_out,
  output logic        de_out,
  output logic [5:0]  r_out,
  output logic [5:0]  g_out,
  output logic [5:0]  b_out
);

  if (H_TOTAL > 1024 || V_TOTAL > 512) begin : g_bad_total
    $error("video_sync_gen: H_TOTAL/V_TOTAL exceed counter width");
  end
  if (H_SYNC >= H_START || V_SYNC >= V_START) begin : g_bad_sync
    $error("video_sync_gen: sync pulse must end before the active area starts");
  end
  if (H_START + H_ACTIVE > H_TOTAL || V_START + V_ACTIVE > V_TOTAL) begin : g_bad_active
    $error("video_sync_gen: active area extends past the end of the line/frame");
  end
  if (H_ACTIVE == 0 || (H_ACTIVE % 8) != 0) begin : g_bad_bars
    $error("video_sync_gen: H_ACTIVE must be a non-zero multiple of 8");
  end

  localparam logic [9:0]  H_LAST  = 10'(H_TOTAL - 1);
  localparam logic [8:0]  V_LAST  = 9'(V_TOTAL - 1);
  localparam logic [9:0]  H_SYNCW = 10'(H_SYNC);
  localparam logic [8:0]  V_SYNCW = 9'(V_SYNC);
  localparam logic [10:0] H_BEG   = 11'(H_START);
  localparam logic [10:0] H_END   = 11'(H_START + H_ACTIVE);
  localparam logic [9:0]  V_BEG   = 10'(V_START);
  localparam logic [9:0]  V_END   = 10'(V_START + V_ACTIVE);

  logic [9:0]  hcnt;
  logic [8:0]  vcnt;
  logic        hs0, vs0, act0, frame_start;
  logic [9:0]  x1;
  logic [8:0]  y1;
  pattern_t    pat_q;
  logic [17:0] pat_rgb;

  // Stage 0: sync and active-area decode straight from the counters.
  assign hs0  = (hcnt >= H_SYNCW);
  assign vs0  = (vcnt >= V_SYNCW);
  assign act0 = ({1'b0, hcnt} >= H_BEG) && ({1'b0, hcnt} < H_END) &&
                ({1'b0, vcnt} >= V_BEG) && ({1'b0, vcnt} < V_END);
  assign frame_start = (hcnt == 10'd0) && (vcnt == 9'd0);

  assign pix_req = act0 & clken_pix;
  assign pix_x   = act0 ? (hcnt - 10'(H_START)) : 10'd0;
  assign pix_y   = act0 ? (vcnt - 9'(V_START)) : 9'd0;

  // Pixel and line counters, advancing only on enabled pixel clocks.
  always_ff @(posedge clk_pix or negedge rst_n) begin
    if (!rst_n) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (clken_pix) begin
      if (hcnt == H_LAST) begin
        hcnt <= '0;
        vcnt <= (vcnt == V_LAST) ? 9'd0 : vcnt + 9'd1;
      end else begin
        hcnt <= hcnt + 10'd1;
      end
    end
  end

  // Pattern select is sampled only at frame start so a frame is never mixed.
  always_ff @(posedge clk_pix or negedge rst_n) begin
    if (!rst_n) begin
      pat_q <= PAT_EXT;
    end else if (clken_pix && frame_start) begin
      pat_q <= pattern_t'(pattern);
    end
  end

  // Stage 1: one enabled cycle behind the counters, matching the external source latency.
  always_ff @(posedge clk_pix or negedge rst_n) begin
    if (!rst_n) begin
      hs_out <= 1'b1;
      vs_out <= 1'b1;
      de_out <= 1'b0;
      x1     <= '0;
      y1     <= '0;
    end else if (clken_pix) begin
      hs_out <= hs0;
      vs_out <= vs0;
      de_out <= act0;
      x1     <= pix_x;
      y1     <= pix_y;
    end
  end

  video_pattern #(
    .H_ACTIVE (H_ACTIVE),
    .V_ACTIVE (V_ACTIVE)
  ) u_pattern (
    .x       (x1),
    .y       (y1),
    .pat     (pat_q),
    .pix_rgb (pix_rgb),
    .rgb     (pat_rgb)
  );

  // Colour is blanked outside the active area; pix_rgb arrives in this same stage.
  assign {r_out, g_out, b_out} = de_out ? pat_rgb : 18'd0;

endmodule

// File: tb/tb_video_sync_gen.sv
// tb/tb_video_sync_gen.sv - directed self-checking bench for video_sync_gen on a reduced timing
module tb_video_sync_gen;

  localparam int H_TOTAL  = 100;
  localparam int H_SYNC   = 8;
  localparam int H_START  = 20;
  localparam int H_ACTIVE = 64;
  localparam int V_TOTAL  = 30;
  localparam int V_SYNC   = 3;
  localparam int V_START  = 5;
  localparam int V_ACTIVE = 20;
  localparam int FRAME    = H_TOTAL * V_TOTAL;

  logic        clk_pix = 1'b0;
  logic        rst_n;
  logic        clken_pix;
  logic [1:0]  pattern;
  logic        pix_req;
  logic [9:0]  pix_x;
  logic [8:0]  pix_y;
  logic [17:0] pix_rgb;
  logic        hs_out, vs_out, de_out;
  logic [5:0]  r_out, g_out, b_out;

  video_sync_gen #(
    .H_TOTAL (H_TOTAL), .H_SYNC (H_SYNC), .H_START (H_START), .H_ACTIVE (H_ACTIVE),
    .V_TOTAL (V_TOTAL), .V_SYNC (V_SYNC), .V_START (V_START), .V_ACTIVE (V_ACTIVE)
  ) dut (
    .clk_pix   (clk_pix),
    .rst_n     (rst_n),
    .clken_pix (clken_pix),
    .pattern   (pattern),
    .pix_req   (pix_req),
    .pix_x     (pix_x),
    .pix_y     (pix_y),
    .pix_rgb   (pix_rgb),
    .hs_out    (hs_out),
    .vs_out    (vs_out),
    .de_out    (de_out),
    .r_out     (r_out),
    .g_out     (g_out),
    .b_out     (b_out)
  );

  always #5 clk_pix = ~clk_pix;

  int n_checks = 0;
  int n_fail   = 0;

  // model state
  int         hm, vm;
  logic [1:0] mpat;
  logic [20:0] prev_out;
  logic       prev_hs, prev_vs;

  // per-frame statistics
  int n_en, hs_falls, first_fall, last_fall, bad_period, hs_low;
  int vs_falls, vs_fall_at, vs_low, de_cnt, err;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [17:0] exp_rgb(input logic [1:0] p, input int x, input int y);
    int i;
    logic [5:0] r, g, b;
    case (p)
      2'b00: return {6'(x), 6'(y), 6'h2A};
      2'b01: begin
        i = x / (H_ACTIVE / 8);
        r = ((i & 2) != 0) ? 6'd63 : 6'd0;
        g = ((i & 4) != 0) ? 6'd63 : 6'd0;
        b = ((i & 1) != 0) ? 6'd63 : 6'd0;
        return {r, g, b};
      end
      2'b10: begin
        if ((x % 32) == 0 || (y % 32) == 0 || x == H_ACTIVE - 1 || y == V_ACTIVE - 1)
          return 18'h3FFFF;
        return 18'h0;
      end
      default: return 18'h0;
    endcase
  endfunction

  task automatic clear_stats();
    n_en = 0; hs_falls = 0; first_fall = -1; last_fall = 0; bad_period = 0; hs_low = 0;
    vs_falls = 0; vs_fall_at = -1; vs_low = 0; de_cnt = 0; err = 0;
  endtask

  // One clk_pix cycle: drive enable, check stage 0 against the model, act as the pixel
  // source, then check stage 1 against the model position from before the edge.
  task automatic tick(input bit en);
    int ph, pv;
    bit act;
    logic [17:0] nxt, rgb;
    logic [20:0] now;
    clken_pix = en;
    #1;
    ph = hm;
    pv = vm;
    act = (ph >= H_START) && (ph < H_START + H_ACTIVE) && (pv >= V_START) && (pv < V_START + V_ACTIVE);
    if (pix_req !== (en && act)) err++;
    if (act) begin
      if (pix_x !== 10'(ph - H_START) || pix_y !== 9'(pv - V_START)) err++;
    end else if (pix_x !== 10'd0 || pix_y !== 9'd0) begin
      err++;
    end
    nxt = pix_req ? {pix_x[5:0], pix_y[5:0], 6'h2A} : pix_rgb;
    if (en && hm == 0 && vm == 0) mpat = pattern;
    @(posedge clk_pix);
    #1;
    pix_rgb = nxt;
    #1;
    rgb = {r_out, g_out, b_out};
    now = {hs_out, vs_out, de_out, rgb};
    if (en) begin
      if (hm == H_TOTAL - 1) begin
        hm = 0;
        vm = (vm == V_TOTAL - 1) ? 0 : vm + 1;
      end else begin
        hm++;
      end
      n_en++;
      if (hs_out !== (ph >= H_SYNC)) err++;
      if (vs_out !== (pv >= V_SYNC)) err++;
      if (de_out !== act) err++;
      if (rgb !== (act ? exp_rgb(mpat, ph - H_START, pv - V_START) : 18'h0)) err++;
      if (prev_hs && !hs_out) begin
        hs_falls++;
        if (first_fall < 0) first_fall = n_en;
        else if (n_en - last_fall != H_TOTAL) bad_period++;
        last_fall = n_en;
      end
      if (!hs_out) hs_low++;
      if (prev_vs && !vs_out) begin
        vs_falls++;
        vs_fall_at = n_en;
      end
      if (!vs_out) vs_low++;
      if (de_out) de_cnt++;
      if (act && mpat == 2'b01 && pv == V_START) begin
        if (ph == H_START)      check_eq("bars_first_px", 32'(rgb), 32'h0);
        if (ph == H_START + 8)  check_eq("bars_x8", 32'(rgb), 32'h0003F);
        if (ph == H_START + 63) check_eq("bars_x63", 32'(rgb), 32'h3FFFF);
      end
      if (act && mpat == 2'b00 && ph == H_START + 5 && pv == V_START + 7)
        check_eq("ext_x5_y7", 32'({de_out, rgb}), 32'({1'b1, 6'h05, 6'h07, 6'h2A}));
    end else if (now !== prev_out) begin
      err++;
    end
    prev_out = now;
    prev_hs = hs_out;
    prev_vs = vs_out;
  endtask

  task automatic run_frame(input string tag, input int duty, input int chg_line, input logic [1:0] new_pat);
    int cyc;
    clear_stats();
    cyc = 0;
    while (n_en < FRAME && cyc < 20 * FRAME) begin
      if (chg_line >= 0 && vm == chg_line && hm == 0) pattern = new_pat;
      tick($urandom_range(0, 99) < duty);
      cyc++;
    end
    check_eq({tag, "_clkens"}, 32'(n_en), 32'(FRAME));
    check_eq({tag, "_hs_pulses"}, 32'(hs_falls), 32'(V_TOTAL));
    check_eq({tag, "_hs_first"}, 32'(first_fall), 32'd1);
    check_eq({tag, "_hs_period_bad"}, 32'(bad_period), 32'd0);
    check_eq({tag, "_hs_low"}, 32'(hs_low), 32'(H_SYNC * V_TOTAL));
    check_eq({tag, "_vs_pulses"}, 32'(vs_falls), 32'd1);
    check_eq({tag, "_vs_fall_at"}, 32'(vs_fall_at), 32'd1);
    check_eq({tag, "_vs_low"}, 32'(vs_low), 32'(V_SYNC * H_TOTAL));
    check_eq({tag, "_de_count"}, 32'(de_cnt), 32'(H_ACTIVE * V_ACTIVE));
    check_eq({tag, "_pixel_errors"}, 32'(err), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int guard;
    rst_n     = 1'b0;
    clken_pix = 1'b1;
    pattern   = 2'b01;
    pix_rgb   = 18'h0;
    hm = 0; vm = 0; mpat = 2'b00;

    repeat (3) @(posedge clk_pix);
    #1;
    check_eq("rst_hs", 32'(hs_out), 32'd1);
    check_eq("rst_vs", 32'(vs_out), 32'd1);
    check_eq("rst_de", 32'(de_out), 32'd0);
    check_eq("rst_rgb", 32'({r_out, g_out, b_out}), 32'h0);
    check_eq("rst_req", 32'(pix_req), 32'd0);

    rst_n = 1'b1;
    prev_out = {hs_out, vs_out, de_out, r_out, g_out, b_out};
    prev_hs = hs_out;
    prev_vs = vs_out;

    run_frame("f1_bars", 100, 10, 2'b00);
    run_frame("f2_ext", 100, 10, 2'b01);
    run_frame("f3_bars_duty30", 30, 10, 2'b10);

    clear_stats();
    guard = 0;
    while (!(hm == H_START + 1 && vm == 10) && guard < FRAME) begin
      tick(1'b1);
      guard++;
    end
    check_eq("grid_err", 32'(err), 32'd0);
    check_eq("grid_before_rst", 32'({de_out, r_out, g_out, b_out}), 32'({1'b1, 18'h3FFFF}));

    rst_n = 1'b0;
    #1;
    check_eq("rst_mid_hs", 32'(hs_out), 32'd1);
    check_eq("rst_mid_vs", 32'(vs_out), 32'd1);
    check_eq("rst_mid_de", 32'(de_out), 32'd0);
    check_eq("rst_mid_rgb", 32'({r_out, g_out, b_out}), 32'h0);
    repeat (2) @(posedge clk_pix);
    #1;
    rst_n = 1'b1;
    hm = 0; vm = 0; mpat = 2'b00;
    prev_out = {hs_out, vs_out, de_out, r_out, g_out, b_out};
    prev_hs = hs_out;
    prev_vs = vs_out;

    run_frame("f5_after_rst", 100, -1, 2'b00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
